// File: rtl/fnd_scan_decoder_if.sv
// Signal bundle between an FND scan source (anodes/segments) and the scan decoder.
// The master drives the display lines; the slave reports decoded frames.
interface fnd_scan_decoder_if;
   logic [7:0]  seg_in;
   logic [3:0]  an_in;
   logic [13:0] value_out;
   logic [15:0] digits_out;
   logic        frame_valid;
   logic        seg_err;
   logic        timeout;

   modport master (
      output seg_in, an_in,
      input  value_out, digits_out, frame_valid, seg_err, timeout
   );

   modport slave (
      input  seg_in, an_in,
      output value_out, digits_out, frame_valid, seg_err, timeout
   );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Snoops a 4-digit multiplexed FND bus, decodes each settled digit back to BCD
// and converts a complete frame to a 14-bit binary value.
module fnd_scan_decoder #(
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned TIMEOUT_CYC = 500_000
) (
   input logic               clk,
   input logic               reset,
   fnd_scan_decoder_if.slave fnd_io
);

   localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);
   localparam logic [SW-1:0] SettleMax = SW'(SETTLE_CYC);
   localparam logic [SW-1:0] SettleHit = SW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] ToLast    = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] ToFire    = TW'(TIMEOUT_CYC - 2);

   typedef enum logic [1:0] {StIdle, StCollect, StConvert, StDone} state_e;

   state_e          state_q, state_d;
   logic [6:0]      seg_meta_q, seg_sync_q;
   logic [3:0]      an_meta_q, an_sync_q, an_prev_q;
   logic [SW-1:0]   settle_q, settle_d;
   logic [3:0][3:0] slot_q, slot_d, conv_q, conv_d;
   logic [3:0]      got_q, got_d, ok_q, ok_d, got_base, ok_base;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [13:0]     acc_q, acc_d, acc_next, value_q, value_d;
   logic [15:0]     digits_q, digits_d;
   logic [1:0]      step_q, step_d, an_idx;
   logic [3:0]      dec_val;
   logic            fv_q, fv_d, err_q, err_d, to_q, to_d;
   logic            an_blank, stable, strobe, dec_ok, clear, drop, frame_start;

   always_comb begin
      an_blank = 1'b0;
      an_idx   = 2'd0;
      case (an_sync_q)
         4'b1110: an_idx = 2'd0;
         4'b1101: an_idx = 2'd1;
         4'b1011: an_idx = 2'd2;
         4'b0111: an_idx = 2'd3;
         default: an_blank = 1'b1;
      endcase
   end

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'd0;
      case (seg_sync_q)
         7'b1000000: dec_val = 4'd0;
         7'b1111001: dec_val = 4'd1;
         7'b0100100: dec_val = 4'd2;
         7'b0110000: dec_val = 4'd3;
         7'b0011001: dec_val = 4'd4;
         7'b0010010: dec_val = 4'd5;
         7'b0000010: dec_val = 4'd6;
         7'b1111000: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0010000: dec_val = 4'd9;
         default:    dec_ok  = 1'b0;
      endcase
   end

   // Saturating at SETTLE_CYC guarantees a single strobe per anode activation.
   assign stable   = !an_blank && (an_sync_q == an_prev_q);
   assign strobe   = stable && (settle_q == SettleHit);
   assign settle_d = !stable ? '0 : (settle_q == SettleMax) ? settle_q : settle_q + 1'b1;

   // Digits are folded most-significant first: conv_q[3] is the thousands digit.
   assign acc_next = acc_q * 14'd10 + {10'd0, conv_q[2'd3 - step_q]};

   always_comb begin
      state_d  = state_q;
      clear    = 1'b0;
      drop     = 1'b0;
      acc_d    = acc_q;
      step_d   = step_q;
      conv_d   = conv_q;
      value_d  = value_q;
      digits_d = digits_q;
      fv_d     = 1'b0;
      to_d     = 1'b0;
      err_d    = strobe && !dec_ok;
      case (state_q)
         StIdle: if (strobe) state_d = StCollect;
         StCollect: begin
            if (got_q == 4'hF) begin
               clear = 1'b1;
               if (ok_q == 4'hF) begin
                  state_d = StConvert;
                  conv_d  = slot_q;
                  acc_d   = '0;
                  step_d  = '0;
               end else begin
                  state_d = StIdle;
               end
            end else if (tcnt_q >= ToFire) begin
               drop    = 1'b1;
               to_d    = 1'b1;
               state_d = StIdle;
            end
         end
         StConvert: begin
            acc_d  = acc_next;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               state_d  = StDone;
               value_d  = acc_next;
               digits_d = conv_q;
               fv_d     = 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      got_base    = clear ? '0 : got_q;
      ok_base     = clear ? '0 : ok_q;
      frame_start = strobe && !drop && (got_base == '0);
      slot_d      = slot_q;
      got_d       = got_base;
      ok_d        = ok_base;
      if (drop) begin
         got_d = '0;
         ok_d  = '0;
      end else if (strobe) begin
         slot_d[an_idx] = dec_val;
         got_d[an_idx]  = 1'b1;
         ok_d[an_idx]   = dec_ok;
      end
      // Digits caught during CONVERT/DONE already belong to the next frame.
      if (state_d == StIdle && got_d != '0) state_d = StCollect;

      if (frame_start)                          tcnt_d = '0;
      else if (got_q != '0 && tcnt_q != ToLast) tcnt_d = tcnt_q + 1'b1;
      else                                      tcnt_d = tcnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_meta_q <= 7'h7F;
         seg_sync_q <= 7'h7F;
         an_meta_q  <= 4'hF;
         an_sync_q  <= 4'hF;
         an_prev_q  <= 4'hF;
         settle_q   <= '0;
         state_q    <= StIdle;
         slot_q     <= '0;
         conv_q     <= '0;
         got_q      <= '0;
         ok_q       <= '0;
         tcnt_q     <= '0;
         acc_q      <= '0;
         step_q     <= '0;
         value_q    <= '0;
         digits_q   <= '0;
         fv_q       <= 1'b0;
         err_q      <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         seg_meta_q <= fnd_io.seg_in[6:0];
         seg_sync_q <= seg_meta_q;
         an_meta_q  <= fnd_io.an_in;
         an_sync_q  <= an_meta_q;
         an_prev_q  <= an_sync_q;
         settle_q   <= settle_d;
         state_q    <= state_d;
         slot_q     <= slot_d;
         conv_q     <= conv_d;
         got_q      <= got_d;
         ok_q       <= ok_d;
         tcnt_q     <= tcnt_d;
         acc_q      <= acc_d;
         step_q     <= step_d;
         value_q    <= value_d;
         digits_q   <= digits_d;
         fv_q       <= fv_d;
         err_q      <= err_d;
         to_q       <= to_d;
      end
   end

   assign fnd_io.value_out   = value_q;
   assign fnd_io.digits_out  = digits_q;
   assign fnd_io.frame_valid = fv_q;
   assign fnd_io.seg_err     = err_q;
   assign fnd_io.timeout     = to_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench for fnd_scan_decoder: scan tasks queue expected events with their
// exact arrival cycle, an independent monitor pops and compares on every output pulse.
module tb_fnd_scan_decoder;

   localparam int SETTLE = 4;
   localparam int TMO    = 200;
   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      int          kind;  // 0 frame, 1 seg_err, 2 timeout
      int          cyc;
      logic [13:0] val;
      logic [15:0] dig;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   frames_seen = 0;
   exp_t exp_q[$];

   fnd_scan_decoder_if fnd_if ();

   fnd_scan_decoder #(
      .SETTLE_CYC  (SETTLE),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .fnd_io (fnd_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int kind, input int at, input logic [13:0] v,
                           input logic [15:0] d);
      exp_t e;
      e.kind = kind;
      e.cyc  = at;
      e.val  = v;
      e.dig  = d;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; holds the digit for 'dwell' cycles.
   task automatic drive(input int idx, input logic [7:0] seg, input int dwell);
      logic [3:0] an;
      an = 4'b0001 << idx;
      fnd_if.an_in  = ~an;
      fnd_if.seg_in = seg;
      repeat (dwell) @(negedge clk);
   endtask

   // Strobe lands SETTLE+3 cycles after the drive; frame_valid 5 cycles after the 4th strobe.
   task automatic scan(input logic [15:0] bcd, input int dwell, input int bad_idx,
                       input bit exp_frame, input logic [13:0] exp_val, input bit dp_on);
      logic [7:0] seg;
      logic [3:0] d;
      for (int i = 0; i < 4; i++) begin
         d   = bcd[i*4 +: 4];
         seg = (i == bad_idx) ? 8'hFF : SEG_TAB[d];
         if (dp_on) seg[7] = 1'b0;
         if (i == bad_idx) push_exp(1, cyc + SETTLE + 3, '0, '0);
         if (i == 3 && exp_frame) push_exp(0, cyc + SETTLE + 8, exp_val, bcd);
         drive(i, seg, dwell);
      end
   endtask

   task automatic blank(input int n);
      fnd_if.an_in  = 4'hF;
      fnd_if.seg_in = 8'hFF;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_value_out"}, int'(fnd_if.value_out), 0);
      chk({tag, "_digits_out"}, int'(fnd_if.digits_out), 0);
      chk({tag, "_frame_valid"}, int'(fnd_if.frame_valid), 0);
      chk({tag, "_seg_err"}, int'(fnd_if.seg_err), 0);
      chk({tag, "_timeout"}, int'(fnd_if.timeout), 0);
   endtask

   always @(negedge clk) begin
      if (reset && (fnd_if.frame_valid || fnd_if.seg_err || fnd_if.timeout)) begin
         int   kind;
         exp_t e;
         kind = fnd_if.frame_valid ? 0 : (fnd_if.seg_err ? 1 : 2);
         if (kind == 0) frames_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: actual kind %0d at cycle %0d required none",
                     kind, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (e.kind == 0) begin
               chk("value_out", int'(fnd_if.value_out), int'(e.val));
               chk("digits_out", int'(fnd_if.digits_out), int'(e.dig));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b0;
      fnd_if.an_in  = 4'hF;
      fnd_if.seg_in = 8'hFF;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      reset = 1'b1;
      repeat (4) @(negedge clk);

      scan(16'h1234, 8, -1, 1'b1, 14'd1234, 1'b0);
      scan(16'h0000, 8, -1, 1'b1, 14'd0, 1'b0);
      scan(16'h0000, 8, -1, 1'b1, 14'd0, 1'b0);
      scan(16'h9999, 8, -1, 1'b1, 14'd9999, 1'b1);
      scan(16'h9999, 8, -1, 1'b1, 14'd9999, 1'b1);

      // Dwell shorter than the settle window must never strobe.
      scan(16'h1234, 3, -1, 1'b0, 14'd0, 1'b0);
      scan(16'h1234, 3, -1, 1'b0, 14'd0, 1'b0);
      chk("frames_after_short_dwell", frames_seen, 5);
      scan(16'h0815, 8, -1, 1'b1, 14'd815, 1'b0);

      scan(16'h0321, 8, 2, 1'b0, 14'd0, 1'b0);
      blank(10);
      chk("held_value_after_bad_frame", int'(fnd_if.value_out), 815);
      chk("held_digits_after_bad_frame", int'(fnd_if.digits_out), 'h0815);

      push_exp(2, cyc + SETTLE + 2 + TMO, '0, '0);
      drive(0, SEG_TAB[3], 8);
      drive(1, SEG_TAB[2], 8);
      drive(2, SEG_TAB[1], 8);
      blank(TMO);
      scan(16'h0042, 8, -1, 1'b1, 14'd42, 1'b0);

      // Reset lands 2 cycles into CONVERT of 5678.
      drive(0, SEG_TAB[8], 8);
      drive(1, SEG_TAB[7], 8);
      drive(2, SEG_TAB[6], 8);
      drive(3, SEG_TAB[5], SETTLE + 5);
      reset = 1'b0;
      #1;
      chk_zero_outputs("mid_convert_reset");
      fnd_if.an_in  = 4'hF;
      fnd_if.seg_in = 8'hFF;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      scan(16'h5678, 8, -1, 1'b1, 14'd5678, 1'b0);

      blank(20);
      chk("pending_expectations", exp_q.size(), 0);
      chk("frames_total", frames_seen, 8);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
